// File: rtl/disk_spin_animator_if.sv
// disk_spin_animator_if: control inputs and display outputs of the spin animator
interface disk_spin_animator_if #(parameter int NUM_DIGITS = 4);
  logic Start, Stop, Dir, Continuous;
  logic [8*NUM_DIGITS-1:0] SSeg;
  logic Busy, Done;
  modport master (output Start, Stop, Dir, Continuous, input SSeg, Busy, Done);
  modport slave (input Start, Stop, Dir, Continuous, output SSeg, Busy, Done);
endinterface

// File: rtl/disk_spin_animator.sv
// disk_spin_animator: single lit segment chasing the outer perimeter of an N-digit seven-segment display
module disk_spin_animator #(
  parameter int NUM_DIGITS = 4,
  parameter int PRESCALE = 4,
  parameter int LAPS = 2,
  parameter int SEG_ACTIVE_LOW = 1
) (
  input logic Clk,
  input logic nReset,
  disk_spin_animator_if.slave bus
);
  localparam int N = NUM_DIGITS;
  localparam int P = 2*N+4;
  localparam int PW = $clog2(P);
  localparam int SW = PRESCALE > 1 ? $clog2(PRESCALE) : 1;
  localparam int LW = $clog2(LAPS+1);
  localparam logic [8*N-1:0] BLANK = SEG_ACTIVE_LOW != 0 ? '1 : '0;
  typedef enum logic {IDLE, SPIN} state_t;
  state_t state_q, state_d;
  logic [PW-1:0] pos_q, pos_d, pos_step;
  logic [SW-1:0] pre_q, pre_d;
  logic [LW-1:0] laps_q, laps_d;
  logic dir_q, dir_d, cont_q, cont_d, busy_q, busy_d, done_q, done_d, step, wrap, last;
  logic [8*N-1:0] sseg_q, sseg_d;
  int p, lit;
  always_comb begin
    step = pre_q == SW'(PRESCALE-1);
    pos_step = dir_q ? (pos_q == '0 ? PW'(P-1) : pos_q - PW'(1)) : (pos_q == PW'(P-1) ? '0 : pos_q + PW'(1));
    wrap = step && pos_step == '0;
    last = wrap && !cont_q && laps_q == LW'(LAPS-1);
    state_d = state_q;
    pos_d = pos_q;
    pre_d = pre_q;
    laps_d = laps_q;
    dir_d = dir_q;
    cont_d = cont_q;
    done_d = 1'b0;
    if (state_q == IDLE) begin
      if (bus.Start && !bus.Stop) begin
        state_d = SPIN;
        pos_d = '0;
        pre_d = '0;
        laps_d = '0;
        dir_d = bus.Dir;
        cont_d = bus.Continuous;
      end
    end else if (bus.Stop || last) begin
      state_d = IDLE;
      done_d = 1'b1;
    end else begin
      pre_d = step ? '0 : pre_q + SW'(1);
      pos_d = step ? pos_step : pos_q;
      laps_d = wrap && !cont_q ? laps_q + LW'(1) : laps_q;
    end
    busy_d = state_d == SPIN;
    p = int'(pos_d);
    lit = p < N ? 8*(N-1-p) : p == N ? 1 : p == N+1 ? 2 : p < 2*N+2 ? 8*(p-N-2)+3 : p == 2*N+2 ? 8*(N-1)+4 : 8*(N-1)+5;
    for (int i = 0; i < 8*N; i++) sseg_d[i] = BLANK[i] ^ (busy_d && i == lit);
  end
  always_ff @(posedge Clk or posedge nReset) begin
    if (nReset) begin
      state_q <= IDLE;
      pos_q <= '0;
      pre_q <= '0;
      laps_q <= '0;
      dir_q <= 1'b0;
      cont_q <= 1'b0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      sseg_q <= BLANK;
    end else begin
      state_q <= state_d;
      pos_q <= pos_d;
      pre_q <= pre_d;
      laps_q <= laps_d;
      dir_q <= dir_d;
      cont_q <= cont_d;
      busy_q <= busy_d;
      done_q <= done_d;
      sseg_q <= sseg_d;
    end
  end
  assign bus.SSeg = sseg_q;
  assign bus.Busy = busy_q;
  assign bus.Done = done_q;
endmodule

// File: doc/disk_spin_animator.md
# disk_spin_animator

Parametrised multi-digit successor to the single-digit disk spin animation top. A single lit segment chases around the outer perimeter of an N-digit seven-segment display, clockwise or counter-clockwise. It runs either a fixed number of laps or continuously until stopped. All digits are driven in parallel from registered outputs, and the block sits directly in front of the display pins.

## Interface

- NUM_DIGITS, 4: number of digits, N ≥ 1; the perimeter has P = 2N+4 positions.
- PRESCALE, 4: clock cycles per animation step, ≥ 1.
- LAPS, 2: laps per run in one-shot mode, ≥ 1.
- SEG_ACTIVE_LOW, 1: 1 means lit segment = 0 and blank = 1; 0 inverts this.

Ports:
- Clk  in  1  system clock, rising edge.
- nReset  in  1  **asynchronous, active-high reset**; the name is kept for codebase consistency.
- Start  in  1  level, sampled on each Clk edge; starts a run from IDLE.
- Stop  in  1  level; ends a run.
- Dir  in  1  0 = clockwise, 1 = counter-clockwise; latched when Start is accepted.
- Continuous  in  1  1 = run until Stop, 0 = run LAPS laps; latched when Start is accepted.
- SSeg  out  8*N  digit i occupies SSeg[8i+7:8i]; digit 0 is rightmost; bit order {dp,g,f,e,d,c,b,a}.
- Busy  out  1  high while in SPIN.
- Done  out  1  one-cycle pulse when a run ends, whether by lap count or by Stop.

## Operation

- States:
  - IDLE: all segments blank, Busy = 0.
  - SPIN: exactly one segment lit, Busy = 1.
- IDLE → SPIN when Start = 1 and Stop = 0.
  - Latches Dir and Continuous.
  - Sets pos = 0, prescaler = 0, laps = 0.
- Position map for pos 0..P-1:
  - 0..N-1: segment a of digit N-1-pos (top edge, left to right).
  - N: segment b of digit 0.
  - N+1: segment c of digit 0.
  - N+2..2N+1: segment d of digit pos-(N+2) (bottom edge, right to left).
  - 2N+2: segment e of digit N-1.
  - 2N+3: segment f of digit N-1.
- Segments dp and g are never lit.
- Prescaler counts 0..PRESCALE-1. The step occurs on the edge where it equals PRESCALE-1; the prescaler then returns to 0.
- Stepping:
  - Clockwise: pos increments and wraps from P-1 to 0.
  - Counter-clockwise: pos decrements and wraps from 0 to P-1.
- A lap completes on the step that lands pos back on 0, in either direction.
- One-shot mode: on the step completing lap LAPS, go to IDLE instead of showing pos 0; Done pulses.
- Stop = 1 in SPIN: next edge goes to IDLE, blank, Done pulses; Stop overrides a simultaneous step.
- Start = 1 while in SPIN is ignored; no restart occurs and Dir/Continuous are not re-latched.
- Start and Stop both high in IDLE: remain IDLE, no Done pulse.
- Start held high after a run ends: a new run begins on the next edge. This is legal continuous re-triggering.
- Dir and Continuous changing mid-run have no effect.

## Timing

- Reset values:
  - State = IDLE.
  - SSeg all blank: all 1s when SEG_ACTIVE_LOW = 1.
  - Busy = 0, Done = 0.
  - pos, prescaler and laps counters = 0.
- Reset acts immediately, including mid-run; outputs blank with no Done pulse.
- All outputs are registered, with no combinational path from inputs to outputs.
- Start accepted at edge k:
  - Busy = 1 and segment for pos 0 lit from edge k.
  - First step at edge k+PRESCALE; each further step every PRESCALE cycles.
- One-shot run length: exactly LAPS·P·PRESCALE cycles of Busy = 1.
  - Busy falls and Done rises at the same edge; Done is high for one cycle.
- Stop sampled at edge k: Busy = 0, blank and Done = 1 from edge k.
- Counter widths:
  - pos: clog2(P) bits.
  - prescaler: clog2(PRESCALE) bits, minimum 1.
  - laps: clog2(LAPS+1) bits.
  - No overflow is reachable.

## Test plan

All scenarios use N=4, PRESCALE=2, LAPS=1, SEG_ACTIVE_LOW=1, so P=12.

- Reset:
  - Stimulus: assert nReset mid-cycle.
  - Response: SSeg = 32'hFFFFFFFF, Busy = 0, Done = 0 without waiting for a clock edge.
- Clockwise one-shot:
  - Stimulus: 1-cycle Start pulse with Dir = 0.
  - Response: digit 3 = 8'hFE first. Sequence then runs a3, a2, a1, a0, b0, c0, d0, d1, d2, d3, e3, f3, each held 2 cycles. After 24 Busy cycles, SSeg blanks and Done pulses once.
- Counter-clockwise:
  - Stimulus: Start with Dir = 1.
  - Response: a3, then f3 (digit 3 = 8'hDF), e3, d3, … a2, each held 2 cycles, 24 Busy cycles total.
- Continuous with Stop:
  - Stimulus: Start with Continuous = 1; Busy holds past 24 cycles, wrapping to a3 at cycle 24. Assert Stop at cycle 30.
  - Response: blank and Done = 1 at that edge.
- Simultaneous events:
  - Stimulus: Start and Stop together in IDLE; separately, Start pulses mid-run; separately, Dir toggled mid-run.
  - Response: Start+Stop stays IDLE; mid-run Start and Dir changes leave the sequence unchanged.
- Reset mid-run:
  - Stimulus: assert nReset at step 5, then release it and pulse Start.
  - Response: immediate blank with no Done; the new run begins at a3 with full length.
